// File: rtl/pwm_sample_stream_if.sv
// Sample-in / PWM-out bundle for pwm_sample_stream.
// master: the sample source and status observer; slave: the PWM block.
interface pwm_sample_stream_if #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 12,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] sound;
  logic              sound_rdy;
  logic              ovf_clr;
  logic              pwm_out;
  logic [OUT_W-1:0]  in_level;
  logic              period_strobe;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic              underrun;

  modport master (
    output sound, sound_rdy, ovf_clr,
    input  pwm_out, in_level, period_strobe, fifo_level, overflow, underrun
  );

  modport slave (
    input  sound, sound_rdy, ovf_clr,
    output pwm_out, in_level, period_strobe, fifo_level, overflow, underrun
  );
endinterface

// File: rtl/pwm_sample_stream.sv
// pwm_sample_stream: buffers signed PCM samples in a small FIFO and plays one
// sample per PWM period (period = 2^OUT_W clocks) as a registered duty cycle.
// Optional feature macro: PWM_SAMPLE_CLAMP_EN clamps each level to
// [MIN_LEVEL, MAX_LEVEL] before it enters the FIFO.
module pwm_sample_stream #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_LEVEL  = 128,
  parameter int MAX_LEVEL  = 3967
) (
  input logic               clk,
  input logic               rst,
  pwm_sample_stream_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  if (MIN_LEVEL > MAX_LEVEL) begin : g_bad_clamp
    $error("MIN_LEVEL must not exceed MAX_LEVEL");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] stg_data;
  logic              stg_rdy;
  logic [DATA_W-1:0] offs;
  logic              unused_offs;
  logic [OUT_W-1:0]  conv_lvl;
  logic [OUT_W-1:0]  wr_lvl;

  logic [OUT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;

  logic [OUT_W-1:0]  cnt;
  logic [OUT_W-1:0]  level_q;
  logic              pwm_q;
  logic              ovf_q;
  logic              udr_q;

  logic strobe, full, empty, wr_en, rd_en, ovf_set, udr_set;

  // Input stage: register the sample and its strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_data <= '0;
      stg_rdy  <= 1'b0;
    end else begin
      stg_data <= bus.sound;
      stg_rdy  <= bus.sound_rdy;
    end
  end

  // Two's complement to offset binary, keep the top OUT_W bits (truncation).
  always_comb begin
    offs     = {~stg_data[DATA_W-1], stg_data[DATA_W-2:0]};
    conv_lvl = offs[DATA_W-1 -: OUT_W];
  end
  assign unused_offs = ^offs;

`ifdef PWM_SAMPLE_CLAMP_EN
  localparam logic [OUT_W-1:0] MIN_L = OUT_W'(MIN_LEVEL);
  localparam logic [OUT_W-1:0] MAX_L = OUT_W'(MAX_LEVEL);

  // Clamp the converted level into the allowed duty range.
  always_comb begin
    wr_lvl = conv_lvl;
    if (conv_lvl < MIN_L) begin
      wr_lvl = MIN_L;
    end else if (conv_lvl > MAX_L) begin
      wr_lvl = MAX_L;
    end
  end
`else
  // Level goes into the FIFO unclamped.
  always_comb begin
    wr_lvl = conv_lvl;
  end
`endif

  // Full/empty are taken from the count before this cycle's push/pop, so a
  // pop never makes room for a same-cycle write and a write never feeds a
  // same-cycle pop.
  always_comb begin
    strobe  = (cnt == '1);
    full    = (count == DEPTH_L);
    empty   = (count == '0);
    wr_en   = stg_rdy & ~full;
    ovf_set = stg_rdy & full;
    rd_en   = strobe & ~empty;
    udr_set = strobe & empty;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_lvl;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en) begin
        count <= count + LVL_W'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - LVL_W'(1);
      end
    end
  end

  // Free-running period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + OUT_W'(1);
    end
  end

  // Duty level load at period end, and the registered PWM comparator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      if (rd_en) level_q <= mem[rd_ptr];
      pwm_q <= (cnt < level_q);
    end
  end

  // Sticky status flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
      if (udr_set)          udr_q <= 1'b1;
      else if (bus.ovf_clr) udr_q <= 1'b0;
    end
  end

  assign bus.pwm_out       = pwm_q;
  assign bus.in_level      = level_q;
  assign bus.period_strobe = strobe;
  assign bus.fifo_level    = count;
  assign bus.overflow      = ovf_q;
  assign bus.underrun      = udr_q;
endmodule
